// File: rtl/div8_pkg.sv
// Shared types and constants for the div8_seq restoring divider.
package div8_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FIXUP = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DIV_WIDTH);

  // Quotient reported for a zero divisor.
  localparam logic [DIV_WIDTH-1:0] DBZ_Q = '1;

endpackage

// File: rtl/div8_seq_sub_cla.sv
// Combinational N-bit carry-lookahead subtractor: diff = a + ~b + 1.
module sub_cla #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  logic [N-1:0] g_c;
  logic [N-1:0] p_c;
  logic [N:0]   c_c;
  logic         pp_c;

  // Each carry is a flattened sum of generate terms gated by the propagate chain.
  always_comb begin
    g_c    = a & ~b;
    p_c    = a ^ ~b;
    c_c    = '0;
    pp_c   = 1'b0;
    c_c[0] = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      c_c[i+1] = g_c[i];
      pp_c     = p_c[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_c[i+1] = c_c[i+1] | (pp_c & g_c[j]);
        pp_c     = pp_c & p_c[j];
      end
      c_c[i+1] = c_c[i+1] | pp_c;
    end
    diff      = p_c ^ c_c[N-1:0];
    no_borrow = c_c[N];
  end

endmodule

// File: rtl/div8_seq.sv
// Sequential restoring divider with valid/ready handshakes; result = {remainder, quotient}.
// Define DIV8_SIGNED_EN for two's-complement operands (adds a FIXUP cycle).
module div8_seq
  import div8_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero
);

  localparam int unsigned CW = (CNT_W > cnt_width(WIDTH)) ? CNT_W : cnt_width(WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     q_q, q_d, r_q, r_d, d_q, d_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 dbz_q, dbz_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [WIDTH:0]       s_c, t_c;
  logic                 nb_c;
`ifdef DIV8_SIGNED_EN
  logic                 neg_q_q, neg_q_d, neg_r_q, neg_r_d;
`endif

  // Extra bit keeps the MSB shifted out of R.
  assign s_c = {r_q, q_q[WIDTH-1]};

  sub_cla #(.N(WIDTH + 1)) u_sub (
    .a        (s_c),
    .b        ({1'b0, d_q}),
    .diff     (t_c),
    .no_borrow(nb_c)
  );

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    result_d    = result_q;
`ifdef DIV8_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          dbz_d      = (divisor == '0);
          cnt_d      = CW'(WIDTH);
          r_d        = '0;
`ifdef DIV8_SIGNED_EN
          q_d     = dividend[WIDTH-1] ? -dividend : dividend;
          d_d     = divisor[WIDTH-1] ? -divisor : divisor;
          neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r_d = dividend[WIDTH-1];
`else
          q_d = dividend;
          d_d = divisor;
`endif
          if (divisor == '0) begin
            r_d     = dividend;
            // Signed cast replicates the all-ones constant to any width.
            q_d     = WIDTH'(signed'(DBZ_Q));
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = nb_c ? t_c[WIDTH-1:0] : s_c[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], nb_c};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef DIV8_SIGNED_EN
          state_d = FIXUP;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef DIV8_SIGNED_EN
      FIXUP: begin
        if (neg_q_q) q_d = -q_q;
        if (neg_r_q) r_d = -r_q;
        state_d = DONE;
      end
`endif
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          result_d    = {r_q, q_q};
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      result_q    <= '0;
`ifdef DIV8_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
      result_q    <= result_d;
`ifdef DIV8_SIGNED_EN
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Directed-vector bench for div8_seq; expected results are hand-computed.
module tb_div8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DIV8_SIGNED_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  div8_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for out_valid; checks latency, result, flag.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_res, input logic exp_dbz, input int exp_lat);
    int lat;
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".res"}, 32'(result), 32'(exp_res));
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(exp_dbz));
  endtask

  // Consume the pending result with out_ready high and confirm return to IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, ".ov0"}, 32'(out_valid), 32'd0);
    check({tag, ".idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = 8'h00;
    divisor   = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst.in_ready",  32'(in_ready),    32'd1);
    check("rst.out_valid", 32'(out_valid),   32'd0);
    check("rst.result",    32'(result),      32'd0);
    check("rst.dbz",       32'(div_by_zero), 32'd0);

`ifndef DIV8_SIGNED_EN
    do_op("u200_7", 8'd200, 8'd7, 16'h041C, 1'b0, LAT);   drain("u200_7");
    do_op("u255_1", 8'd255, 8'd1, 16'h00FF, 1'b0, LAT);   drain("u255_1");
    do_op("u5_9",   8'd5,   8'd9, 16'h0500, 1'b0, LAT);   drain("u5_9");
    do_op("u0_3",   8'd0,   8'd3, 16'h0000, 1'b0, LAT);   drain("u0_3");
    do_op("u255_255", 8'd255, 8'd255, 16'h0001, 1'b0, LAT); drain("u255_255");
    do_op("u100_0", 8'd100, 8'd0, 16'h64FF, 1'b1, 1);     drain("u100_0");
    do_op("u10_3",  8'd10,  8'd3, 16'h0103, 1'b0, LAT);   drain("u10_3");

    out_ready = 1'b0;
    do_op("bp50_6", 8'd50, 8'd6, 16'h0208, 1'b0, LAT);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      dividend = 8'd99;
      divisor  = 8'd5;
      tick();
      check("bp.res",   32'(result),    32'h0208);
      check("bp.ov",    32'(out_valid), 32'd1);
      check("bp.inrdy", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    drain("bp50_6");
    tick();
    check("bp.no_ghost", 32'(out_valid), 32'd0);

    in_valid = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("mid.busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid.ov",     32'(out_valid), 32'd0);
    check("mid.inrdy",  32'(in_ready),  32'd1);
    check("mid.result", 32'(result),    32'd0);
    do_op("u9_2", 8'd9, 8'd2, 16'h0104, 1'b0, LAT); drain("u9_2");
`else
    do_op("sm7_2",    8'hF9, 8'h02, 16'hFFFD, 1'b0, LAT); drain("sm7_2");
    do_op("s80_ff",   8'h80, 8'hFF, 16'h0080, 1'b0, LAT); drain("s80_ff");
    do_op("s100_7",   8'd100, 8'd7, 16'h020E, 1'b0, LAT); drain("s100_7");
    do_op("s9_m2",    8'd9, 8'hFE,  16'h01FC, 1'b0, LAT); drain("s9_m2");
    do_op("sm16_0",   8'hF0, 8'h00, 16'hF0FF, 1'b1, 1);   drain("sm16_0");
    do_op("s10_3",    8'd10, 8'd3,  16'h0103, 1'b0, LAT); drain("s10_3");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
